counter_time_prog: RTL and testbench
====================================

COUNTER_TIME_PROG -- requirements
Module: counter_time_prog

Interface
REQ-001 Parameter WIDTH, default 4: bit width of tempo and load_val.
REQ-002 Parameter MAX_VAL, default 9: terminal count; legal range 1 .. 2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 1: qualifying E cycles per count step; legal range >= 1.
REQ-004 clkt  in  1  single clock; all state updates on its rising edge.
REQ-005 R  in  1  reset; synchronous and active-high.
REQ-006 E  in  1  count enable; when low, counter and prescaler freeze.
REQ-007 dir  in  1  0 = count up, 1 = count down.
REQ-008 mode  in  1  0 = wrap (free-running), 1 = one-shot (stop at terminal).
REQ-009 load  in  1  synchronous parallel-load strobe.
REQ-010 load_val  in  WIDTH  value loaded on load.
REQ-011 tempo  out  WIDTH  current count, registered.
REQ-012 end_time  out  1  one-cycle pulse; terminal step taken.
REQ-013 done  out  1  level; one-shot finished, count halted.

Function
REQ-014 Step tick: asserted when E=1 and the prescaler reaches PRESCALE-1; the prescaler then returns to 0. PRESCALE=1 gives a tick on every cycle with E=1.
REQ-015 States: COUNT and DONE. Only COUNT advances tempo on a tick.
REQ-016 Up (dir=0) tick: tempo+1. At tempo==MAX_VAL, wrap to 0 in wrap mode, or hold MAX_VAL and enter DONE in one-shot.
REQ-017 Down (dir=1) tick: tempo-1. At tempo==0, wrap to MAX_VAL in wrap mode, or hold 0 and enter DONE in one-shot.
REQ-018 end_time is 1 for exactly the cycle after the terminal tick edge (same cycle as the wrapped/held tempo) and is 0 otherwise.
REQ-019 done is 1 while in DONE. In DONE, ticks are ignored and tempo is held.
REQ-020 Changes to dir and mode are sampled per tick and take effect on the next tick; the prescaler is not reset by them.
REQ-021 mode 1->0 while in DONE: return to COUNT on the next cycle without changing tempo.
REQ-022 Priority: R > load > tick.
REQ-023 load: tempo <= min(load_val, MAX_VAL), prescaler <= 0, state <= COUNT, end_time <= 0.
REQ-024 tempo never exceeds MAX_VAL, and arithmetic never leaves the WIDTH range.

Reset
REQ-025 R=1 at a clkt edge: tempo=0, prescaler=0, state=COUNT, end_time=0, done=0; this holds regardless of E, load or state, including mid-count and in DONE.
REQ-026 First tick after R deasserts: after PRESCALE cycles with E=1.

Configuration
REQ-027 Macro COUNTER_TIME_LOAD_EN defined: load and load_val behave per REQ-023.
REQ-028 Macro undefined: ports remain present, load is ignored, and only R restores tempo.

Structure
REQ-029 Shared package counter_time_pkg holds the state encoding (COUNT, DONE) and the mode/dir encoding constants.
REQ-030 The prescaler is sub-module counter_time_tick (parameter PRESCALE; inputs clkt, R, E, clr; output tick).
REQ-031 Elaboration fails if MAX_VAL >= 2**WIDTH, MAX_VAL < 1, or PRESCALE < 1.

Verification
REQ-032 Defaults, dir=0, mode=0, E=1 for 12 cycles after R: tempo 0..9,0,1; end_time high exactly once, with tempo=0.
REQ-033 PRESCALE=3, E=1 for 9 cycles: tempo steps every 3rd cycle to 3; toggling E low for 2 cycles delays all later steps by 2 cycles.
REQ-034 dir=1, mode=1, load_val=2 loaded: tempo 2,1,0, then holds 0; end_time pulses once; done=1 thereafter; further E has no effect.
REQ-035 With macro defined, load_val=15 and MAX_VAL=9: tempo=9. Load asserted on the same cycle as a terminal tick: tempo=min(load_val,9) and no end_time. R on the same cycle as load: tempo=0.
REQ-036 R asserted in DONE and mid-count (tempo=5): next cycle tempo=0, done=0, end_time=0. Without the macro, load=1 leaves tempo unchanged.

Source files
------------

// File: rtl/counter_time_pkg.sv
// Shared encodings for the programmable time counter: FSM states and
// the dir/mode input meanings.
package counter_time_pkg;

    typedef enum logic {
        COUNT = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/counter_time_tick.sv
// Prescaler for counter_time_prog: pulses tick on every PRESCALE-th
// enabled cycle and freezes while E is low.
module counter_time_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clkt,
    input  logic R,
    input  logic E,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_time_tick: PRESCALE must be >= 1");
    end

    assign tick = E && (cnt == LAST);

    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
    always_ff @(posedge clkt) begin
        if (R || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (E) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/counter_time_prog.sv
// Programmable up/down time counter with wrap or one-shot terminal behaviour.
// Define COUNTER_TIME_LOAD_EN to enable the synchronous parallel load.
module counter_time_prog
    import counter_time_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 9,
    parameter int PRESCALE = 1
) (
    input  logic             clkt,
    input  logic             R,
    input  logic             E,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] tempo,
    output logic             end_time,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_T = WIDTH'(MAX_VAL);

    if (MAX_VAL < 1 || MAX_VAL >= 2 ** WIDTH) begin : g_bad_max
        $error("counter_time_prog: MAX_VAL must be in 1 .. 2**WIDTH-1");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] tempo_next;
    logic             end_next;
    logic             tick;
    logic             load_hit;

`ifdef COUNTER_TIME_LOAD_EN
    assign load_hit = load;
`else
    logic unused_load;
    assign load_hit    = 1'b0;
    assign unused_load = ^{load, load_val};
`endif

    counter_time_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clkt (clkt),
        .R    (R),
        .E    (E),
        .clr  (load_hit),
        .tick (tick)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        tempo_next = tempo;
        end_next   = 1'b0;
        if (load_hit) begin
            tempo_next = (load_val > MAX_T) ? MAX_T : load_val;
            state_next = COUNT;
        end else if (state == DONE) begin
            if (mode == MODE_WRAP) begin
                state_next = COUNT;
            end
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (tempo == MAX_T) begin
                    end_next = 1'b1;
                    if (mode == MODE_WRAP) tempo_next = '0;
                    else                   state_next = DONE;
                end else begin
                    tempo_next = tempo + WIDTH'(1);
                end
            end else begin
                if (tempo == '0) begin
                    end_next = 1'b1;
                    if (mode == MODE_WRAP) tempo_next = MAX_T;
                    else                   state_next = DONE;
                end else begin
                    tempo_next = tempo - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clkt) begin
        if (R) begin
            state    <= COUNT;
            tempo    <= '0;
            end_time <= 1'b0;
        end else begin
            state    <= state_next;
            tempo    <= tempo_next;
            end_time <= end_next;
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_counter_time_prog.sv
// Self-checking bench for counter_time_prog: a default instance and a
// PRESCALE=3 instance share stimulus and are compared to an arithmetic model.
module tb_counter_time_prog;

    localparam int MAXV = 9;
`ifdef COUNTER_TIME_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    typedef struct packed {
        int   t;
        int   pre;
        logic dn;
        logic et;
    } mdl_t;

    logic       clkt = 1'b0;
    logic       R, E, dir, mode, load;
    logic [3:0] load_val;
    logic [3:0] t0, t3;
    logic       e0, e3, d0, d3;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;
    mdl_t m0 = '0;
    mdl_t m3 = '0;

    always #5 clkt = ~clkt;

    counter_time_prog dut0 (
        .clkt(clkt), .R(R), .E(E), .dir(dir), .mode(mode), .load(load),
        .load_val(load_val), .tempo(t0), .end_time(e0), .done(d0)
    );

    counter_time_prog #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut3 (
        .clkt(clkt), .R(R), .E(E), .dir(dir), .mode(mode), .load(load),
        .load_val(load_val), .tempo(t3), .end_time(e3), .done(d3)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Count position treated as a number on the ring 0..MAXV; a step that
    // falls off either end is the terminal step.
    function automatic mdl_t mdl_step(input mdl_t m, input int pres, input bit r,
                                      input bit e, input bit d, input bit md,
                                      input bit ld, input int lv);
        mdl_t n;
        bit   tk;
        int   nxt;
        n    = m;
        n.et = 1'b0;
        tk   = 1'b0;
        if (r) begin
            n.t = 0; n.pre = 0; n.dn = 1'b0;
            return n;
        end
        if (LOAD_EN && ld) begin
            n.t = (lv > MAXV) ? MAXV : lv; n.pre = 0; n.dn = 1'b0;
            return n;
        end
        if (e) begin
            n.pre = (m.pre + 1) % pres;
            tk    = (n.pre == 0);
        end
        if (m.dn) begin
            if (!md) n.dn = 1'b0;
        end else if (tk) begin
            nxt = d ? m.t - 1 : m.t + 1;
            if (nxt < 0 || nxt > MAXV) begin
                n.et = 1'b1;
                if (md) n.dn = 1'b1;
                else    n.t  = (nxt + MAXV + 1) % (MAXV + 1);
            end else begin
                n.t = nxt;
            end
        end
        return n;
    endfunction

    always @(posedge clkt) begin
        m0 = mdl_step(m0, 1, R, E, dir, mode, load, int'(load_val));
        m3 = mdl_step(m3, 3, R, E, dir, mode, load, int'(load_val));
    end

    always @(negedge clkt) begin
        if (chk_en) begin
            check("m0_tempo", int'(t0), m0.t);
            check("m0_end",   int'(e0), int'(m0.et));
            check("m0_done",  int'(d0), int'(m0.dn));
            check("m3_tempo", int'(t3), m3.t);
            check("m3_end",   int'(e3), int'(m3.et));
            check("m3_done",  int'(d3), int'(m3.dn));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clkt);
            #1;
        end
    endtask

    int seq [12];
    int ends;

    initial begin
        R = 1'b1; E = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
        cyc(2);
        R = 1'b0;
        chk_en = 1'b1;
        check("rst_tempo", int'(t0), 0);
        check("rst_done",  int'(d0), 0);
        check("rst_end",   int'(e0), 0);

        // Free-running up count with the default prescaler.
        seq  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
        ends = 0;
        E    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("up_seq", int'(t0), seq[i]);
            if (e0) begin
                ends++;
                check("end_at_zero", int'(t0), 0);
            end
            if (i == 9) check("p3_after9", int'(t3), 3);
            cyc(1);
        end
        check("end_count", ends, 1);

        // Two-cycle E stall on the PRESCALE=3 instance.
        R = 1'b1; cyc(1); R = 1'b0;
        cyc(4);  check("p3_first",   int'(t3), 1);
        E = 1'b0; cyc(2); check("p3_frozen",  int'(t3), 1);
        E = 1'b1; cyc(1); check("p3_delay",   int'(t3), 1);
        cyc(1);  check("p3_step2",   int'(t3), 2);
        cyc(2);  check("p3_hold2",   int'(t3), 2);
        cyc(1);  check("p3_step3",   int'(t3), 3);

        // One-shot down count to zero from 2.
        R = 1'b1; cyc(1); R = 1'b0;
        cyc(2);  check("os_start", int'(t0), 2);
        dir = 1'b1; mode = 1'b1;
        cyc(1);  check("os_t1", int'(t0), 1); check("os_e1", int'(e0), 0);
        cyc(1);  check("os_t0", int'(t0), 0); check("os_d0", int'(d0), 0);
        cyc(1);  check("os_term_t", int'(t0), 0); check("os_term_e", int'(e0), 1);
                 check("os_term_d", int'(d0), 1);
        cyc(1);  check("os_after_e", int'(e0), 0); check("os_after_d", int'(d0), 1);
        cyc(3);  check("os_hold_t", int'(t0), 0); check("os_hold_d", int'(d0), 1);

        // Reset from DONE, then reset mid-count.
        E = 1'b0; R = 1'b1; cyc(1); R = 1'b0;
        check("rd_tempo", int'(t0), 0); check("rd_done", int'(d0), 0);
        check("rd_end", int'(e0), 0);
        dir = 1'b0; mode = 1'b0; E = 1'b1;
        cyc(5);  check("mid_five", int'(t0), 5);
        R = 1'b1; cyc(1); R = 1'b0;
        check("rm_tempo", int'(t0), 0); check("rm_done", int'(d0), 0);
        check("rm_end", int'(e0), 0);

        // Leaving DONE by clearing mode keeps tempo.
        dir = 1'b1; mode = 1'b1;
        cyc(1);  check("exit_in_done", int'(d0), 1);
        E = 1'b0;
        cyc(1);  check("exit_still_done", int'(d0), 1);
        mode = 1'b0;
        cyc(1);  check("exit_done_clr", int'(d0), 0); check("exit_tempo", int'(t0), 0);

        // Load behaviour (clamped load, load vs terminal tick, R vs load).
        dir = 1'b0; E = 1'b1;
        cyc(3);  check("pre_load", int'(t0), 3);
        E = 1'b0; load = 1'b1; load_val = 4'd15;
        cyc(1);
        load = 1'b0;
        check("load_clamp", int'(t0), LOAD_EN ? 9 : 3);
        E = 1'b1; load = 1'b1; load_val = 4'd4;
        cyc(1);
        load = 1'b0;
        check("load_vs_tick_t", int'(t0), 4);
        check("load_vs_tick_e", int'(e0), 0);
        R = 1'b1; load = 1'b1; load_val = 4'd7;
        cyc(1);
        R = 1'b0; load = 1'b0;
        check("r_over_load", int'(t0), 0);

        // Mixed tail exercising E gaps and mid-stream dir/mode changes.
        for (int i = 0; i < 40; i++) begin
            E    = (i % 5) != 0;
            dir  = ((i / 13) % 2) != 0;
            mode = (i > 30);
            load = (i == 20);
            load_val = 4'(i % 16);
            cyc(1);
        end
        load = 1'b0;
        cyc(1);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
